sv39_ptw_lite: RTL and testbench

Hardware page-table walker for SV39 that sits on the refill side of the fully-associative TLB. It accepts one TLB miss at a time and walks the three-level page table through a single-outstanding memory read port. It then returns either a TLB update (leaf PTE, 4K/2M/1G size flags, ASID, VPN) or a page fault. Its update outputs map field-for-field onto `tlb_update_t` and drive the TLB's `update_i`.

---
 rtl/sv39_ptw_lite.sv | 338 +++++++++++++++++++++++++++++++++
 tb/tb_sv39_ptw_lite.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sv39_ptw_lite.sv
// -----------------------------------------------------------------------------
// sv39_ptw_lite
//
// SV39 hardware page-table walker on the refill side of a fully-associative
// TLB. It accepts one miss at a time and walks up to three page-table levels
// through a single-outstanding PTE read port. The walk ends in one of two ways:
//   - a registered TLB update pulse (leaf PTE, 4K/2M/1G size flags, ASID, VPN);
//   - a registered page-fault pulse.
//
// Configuration macro:
//   PTW_AD_FAULT_EN  defined   : a leaf whose A bit is clear raises a fault
//                                (software-managed A/D bits).
//                    undefined : the A bit is ignored and the leaf is forwarded.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   flush_i               abort any walk in progress (SFENCE.VMA / satp write)
//   en_translation_i      translation enabled; no miss is accepted when low
//   satp_ppn_i            root page-table PPN, sampled when a miss is accepted
//   asid_i                ASID, sampled when a miss is accepted
//   miss_valid_i/_ready_o TLB miss handshake, carries miss_vaddr_i
//   req_valid_o/_ready_i  PTE read request handshake, carries req_addr_o
//   resp_valid_i          PTE read data valid, carries resp_data_i
//   update_*_o            TLB update (valid is a one-cycle pulse)
//   fault_valid_o         page-fault pulse, carries fault_vaddr_o
//   busy_o                walker not idle
// -----------------------------------------------------------------------------

// Protocol checker for the walker's memory and result interfaces.
module sv39_ptw_lite_chk (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        in_req_i,
    input  logic        resp_valid_i,
    input  logic        req_valid_i,
    input  logic        req_ready_i,
    input  logic [55:0] req_addr_i,
    input  logic        update_valid_i,
    input  logic        fault_valid_i
);

    // A response can only follow an accepted request, never arrive while one is pending.
    a_no_resp_in_req: assert property (@(posedge clk_i) disable iff (rst_i)
        !(in_req_i && resp_valid_i));

    // A stalled request keeps its valid and address until accepted or flushed.
    a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (req_valid_i && !req_ready_i && !flush_i) |=> (req_valid_i && $stable(req_addr_i)));

    // A completed walk reports either an update or a fault, never both.
    a_one_outcome: assert property (@(posedge clk_i) disable iff (rst_i)
        !(update_valid_i && fault_valid_i));

endmodule

module sv39_ptw_lite #(
    parameter int unsigned ASID_WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  en_translation_i,
    input  logic [43:0]           satp_ppn_i,
    input  logic [ASID_WIDTH-1:0] asid_i,
    input  logic                  miss_valid_i,
    input  logic [38:0]           miss_vaddr_i,
    output logic                  miss_ready_o,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic [55:0]           req_addr_o,
    input  logic                  resp_valid_i,
    input  logic [63:0]           resp_data_i,
    output logic                  update_valid_o,
    output logic [26:0]           update_vpn_o,
    output logic [ASID_WIDTH-1:0] update_asid_o,
    output logic                  update_is_2M_o,
    output logic                  update_is_1G_o,
    output logic [63:0]           update_content_o,
    output logic                  fault_valid_o,
    output logic [38:0]           fault_vaddr_o,
    output logic                  busy_o
);

    // Walker states.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Page-table levels; the level number also selects the leaf size.
    localparam logic [1:0] LVL_1G = 2'd2;
    localparam logic [1:0] LVL_2M = 2'd1;
    localparam logic [1:0] LVL_4K = 2'd0;

    // PTE flag bit positions.
    localparam int unsigned PTE_V = 0;
    localparam int unsigned PTE_R = 1;
    localparam int unsigned PTE_W = 2;
    localparam int unsigned PTE_X = 3;
    localparam int unsigned PTE_G = 5;
`ifdef PTW_AD_FAULT_EN
    localparam int unsigned PTE_A = 6;
`endif

    // Invalid PTE: not valid, or the reserved write-only encoding.
    function automatic logic pte_bad(input logic v, input logic r, input logic w);
        logic bad;
        bad = (v == 1'b0) || ((r == 1'b0) && (w == 1'b1));
        return bad;
    endfunction

    // Superpage leaves must have the PPN bits below their size cleared.
    function automatic logic pte_misaligned(input logic [17:0] ppn_lo, input logic [1:0] level);
        logic mis;
        case (level)
            LVL_1G:  mis = (ppn_lo != 18'd0);
            LVL_2M:  mis = (ppn_lo[8:0] != 9'd0);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Nine-bit VPN index of the given level.
    function automatic logic [8:0] vpn_slice(input logic [26:0] vpn, input logic [1:0] level);
        logic [8:0] idx;
        case (level)
            LVL_1G:  idx = vpn[26:18];
            LVL_2M:  idx = vpn[17:9];
            default: idx = vpn[8:0];
        endcase
        return idx;
    endfunction

    // Leaf PTE with the global bit widened to every level walked on the way down.
    function automatic logic [63:0] merge_g(input logic [63:0] pte, input logic g_acc);
        logic [63:0] out;
        out = {pte[63:6], pte[5] | g_acc, pte[4:0]};
        return out;
    endfunction

    // Walk context.
    logic [1:0]            state_q, state_d;
    logic [38:0]           vaddr_q, vaddr_d;
    logic [ASID_WIDTH-1:0] asid_q,  asid_d;
    logic [43:0]           ppn_q,   ppn_d;
    logic [1:0]            level_q, level_d;
    logic                  gacc_q,  gacc_d;

    // Registered results.
    logic                  update_valid_q;
    logic [26:0]           update_vpn_q;
    logic [ASID_WIDTH-1:0] update_asid_q;
    logic                  update_is_2M_q;
    logic                  update_is_1G_q;
    logic [63:0]           update_content_q;
    logic                  fault_valid_q;
    logic [38:0]           fault_vaddr_q;

    logic miss_ready_s;
    logic update_set_s;
    logic fault_set_s;
    logic resp_bad_s;
    logic resp_leaf_s;
    logic resp_misaligned_s;

    // Flush wins over a miss arriving in the same cycle, so the walker is not ready then.
    assign miss_ready_s = (state_q == ST_IDLE) && en_translation_i && !flush_i && !rst_i;

    assign resp_bad_s        = pte_bad(resp_data_i[PTE_V], resp_data_i[PTE_R], resp_data_i[PTE_W]);
    assign resp_leaf_s       = resp_data_i[PTE_R] | resp_data_i[PTE_X];
    assign resp_misaligned_s = pte_misaligned(resp_data_i[27:10], level_q);

    // Next-state and outcome decode for the walk FSM.
    always_comb begin
        state_d      = state_q;
        vaddr_d      = vaddr_q;
        asid_d       = asid_q;
        ppn_d        = ppn_q;
        level_d      = level_q;
        gacc_d       = gacc_q;
        update_set_s = 1'b0;
        fault_set_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (miss_valid_i && miss_ready_s) begin
                    vaddr_d = miss_vaddr_i;
                    asid_d  = asid_i;
                    ppn_d   = satp_ppn_i;
                    level_d = LVL_1G;
                    gacc_d  = 1'b0;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (flush_i) begin
                    // A request accepted in the flush cycle still owes us a response.
                    if (req_ready_i) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (req_ready_i) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (flush_i) begin
                    // A response landing in the flush cycle is dropped right here.
                    if (resp_valid_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (resp_valid_i) begin
                    gacc_d = gacc_q | resp_data_i[PTE_G];
                    if (resp_bad_s) begin
                        fault_set_s = 1'b1;
                        state_d     = ST_IDLE;
                    end else if (resp_leaf_s) begin
                        state_d = ST_IDLE;
                        if (resp_misaligned_s) begin
                            fault_set_s = 1'b1;
                        end else begin
`ifdef PTW_AD_FAULT_EN
                            if (resp_data_i[PTE_A] == 1'b0) begin
                                fault_set_s = 1'b1;
                            end else begin
                                update_set_s = 1'b1;
                            end
`else
                            update_set_s = 1'b1;
`endif
                        end
                    end else if (level_q == LVL_4K) begin
                        // Pointer PTE at the last level has nowhere to go.
                        fault_set_s = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        ppn_d   = resp_data_i[53:10];
                        level_d = level_q - 2'd1;
                        state_d = ST_REQ;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (resp_valid_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Walk context registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            vaddr_q <= 39'd0;
            asid_q  <= '0;
            ppn_q   <= 44'd0;
            level_q <= LVL_1G;
            gacc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vaddr_q <= vaddr_d;
            asid_q  <= asid_d;
            ppn_q   <= ppn_d;
            level_q <= level_d;
            gacc_q  <= gacc_d;
        end
    end

    // Result registers: pulses for one cycle, payload held until the next result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            update_valid_q   <= 1'b0;
            update_vpn_q     <= 27'd0;
            update_asid_q    <= '0;
            update_is_2M_q   <= 1'b0;
            update_is_1G_q   <= 1'b0;
            update_content_q <= 64'd0;
            fault_valid_q    <= 1'b0;
            fault_vaddr_q    <= 39'd0;
        end else begin
            update_valid_q <= update_set_s;
            fault_valid_q  <= fault_set_s;
            if (update_set_s) begin
                update_vpn_q     <= vaddr_q[38:12];
                update_asid_q    <= asid_q;
                update_is_1G_q   <= (level_q == LVL_1G);
                update_is_2M_q   <= (level_q == LVL_2M);
                update_content_q <= merge_g(resp_data_i, gacc_q);
            end
            if (fault_set_s) begin
                fault_vaddr_q <= vaddr_q;
            end
        end
    end

    // The request address depends only on registered context, so it is stable during a stall.
    assign miss_ready_o     = miss_ready_s;
    assign req_valid_o      = (state_q == ST_REQ) && !rst_i;
    assign req_addr_o       = {ppn_q, vpn_slice(vaddr_q[38:12], level_q), 3'b000};
    assign busy_o           = (state_q != ST_IDLE) && !rst_i;
    assign update_valid_o   = update_valid_q;
    assign update_vpn_o     = update_vpn_q;
    assign update_asid_o    = update_asid_q;
    assign update_is_2M_o   = update_is_2M_q;
    assign update_is_1G_o   = update_is_1G_q;
    assign update_content_o = update_content_q;
    assign fault_valid_o    = fault_valid_q;
    assign fault_vaddr_o    = fault_vaddr_q;

    sv39_ptw_lite_chk u_chk (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .in_req_i       (state_q == ST_REQ),
        .resp_valid_i   (resp_valid_i),
        .req_valid_i    (req_valid_o),
        .req_ready_i    (req_ready_i),
        .req_addr_i     (req_addr_o),
        .update_valid_i (update_valid_o),
        .fault_valid_i  (fault_valid_o)
    );

endmodule

// File: tb/tb_sv39_ptw_lite.sv
// Self-checking bench for sv39_ptw_lite: directed walks, flush scenarios and
// randomly generated page tables, each checked against a walk model that
// follows the SV39 translation rules with plain arithmetic.
module tb_sv39_ptw_lite;

    localparam int unsigned AW = 4;
`ifdef PTW_AD_FAULT_EN
    localparam bit AD_EN = 1'b1;
`else
    localparam bit AD_EN = 1'b0;
`endif
    localparam logic [38:0] V4K = 39'h0_4020_3000;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          flush_i;
    logic          en_translation_i;
    logic [43:0]   satp_ppn_i;
    logic [AW-1:0] asid_i;
    logic          miss_valid_i;
    logic [38:0]   miss_vaddr_i;
    logic          miss_ready_o;
    logic          req_valid_o;
    logic          req_ready_i;
    logic [55:0]   req_addr_o;
    logic          resp_valid_i;
    logic [63:0]   resp_data_i;
    logic          update_valid_o;
    logic [26:0]   update_vpn_o;
    logic [AW-1:0] update_asid_o;
    logic          update_is_2M_o;
    logic          update_is_1G_o;
    logic [63:0]   update_content_o;
    logic          fault_valid_o;
    logic [38:0]   fault_vaddr_o;
    logic          busy_o;

    sv39_ptw_lite #(.ASID_WIDTH(AW)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .en_translation_i (en_translation_i),
        .satp_ppn_i       (satp_ppn_i),
        .asid_i           (asid_i),
        .miss_valid_i     (miss_valid_i),
        .miss_vaddr_i     (miss_vaddr_i),
        .miss_ready_o     (miss_ready_o),
        .req_valid_o      (req_valid_o),
        .req_ready_i      (req_ready_i),
        .req_addr_o       (req_addr_o),
        .resp_valid_i     (resp_valid_i),
        .resp_data_i      (resp_data_i),
        .update_valid_o   (update_valid_o),
        .update_vpn_o     (update_vpn_o),
        .update_asid_o    (update_asid_o),
        .update_is_2M_o   (update_is_2M_o),
        .update_is_1G_o   (update_is_1G_o),
        .update_content_o (update_content_o),
        .fault_valid_o    (fault_valid_o),
        .fault_vaddr_o    (fault_vaddr_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Physical memory holding PTEs; absent entries read as zero.
    logic [63:0] mem [logic [55:0]];

    // Expected walk result from the model.
    int          exp_n;
    logic [55:0] exp_addr [0:2];
    bit          exp_upd;
    logic [63:0] exp_content;
    bit          exp_1g;
    bit          exp_2m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic samp();
        @(negedge clk_i);
    endtask

    function automatic logic [63:0] mem_rd(input logic [55:0] a);
        return mem.exists(a) ? mem[a] : 64'd0;
    endfunction

    function automatic logic [63:0] mk_pte(input logic [43:0] ppn, input logic [7:0] flags);
        return {10'd0, ppn, 2'b00, flags};
    endfunction

    // Reference walk: address = ppn*4096 + vpn[level]*8, then the SV39 PTE rules.
    task automatic run_model(input logic [43:0] satp, input logic [38:0] va);
        longint unsigned ppn, vl, idx, a, pppn;
        logic [63:0]     pte;
        int              lvl;
        bit              g;
        ppn = satp; vl = va; lvl = 2; g = 1'b0;
        exp_n = 0; exp_upd = 1'b0; exp_content = 64'd0; exp_1g = 1'b0; exp_2m = 1'b0;
        for (int step = 0; step < 3; step++) begin
            idx = (vl >> (12 + 9 * lvl)) % 512;
            a   = ppn * 4096 + idx * 8;
            exp_addr[step] = a[55:0];
            exp_n++;
            pte  = mem_rd(a[55:0]);
            g    = g | pte[5];
            pppn = (pte >> 10) % (64'd1 << 44);
            if (!pte[0] || (!pte[1] && pte[2])) return;
            if (pte[1] || pte[3]) begin
                if (lvl > 0 && (pppn % (64'd1 << (9 * lvl))) != 0) return;
                if (AD_EN && !pte[6]) return;
                exp_upd     = 1'b1;
                exp_content = pte | (g ? 64'h20 : 64'h0);
                exp_1g      = (lvl == 2);
                exp_2m      = (lvl == 1);
                return;
            end
            if (lvl == 0) return;
            ppn = pppn;
            lvl = lvl - 1;
        end
    endtask

    // Drive one miss, serve every request from mem, then check the single outcome pulse.
    task automatic walk(input logic [38:0] va, input logic [AW-1:0] asid,
                        input int stall, input int delay, input string nm);
        logic [55:0] a;
        logic [63:0] va64;
        run_model(satp_ppn_i, va);
        miss_vaddr_i = va; asid_i = asid; miss_valid_i = 1'b1;
        samp(); chk({nm, ".miss_ready"}, {63'd0, miss_ready_o}, 64'd1);
        tick(); miss_valid_i = 1'b0;
        for (int l = 0; l < exp_n; l++) begin
            req_ready_i = 1'b0;
            for (int s = 0; s < stall; s++) begin
                samp();
                chk({nm, ".stall_valid"}, {63'd0, req_valid_o}, 64'd1);
                chk({nm, ".stall_addr"}, {8'd0, req_addr_o}, {8'd0, exp_addr[l]});
                tick();
            end
            req_ready_i = 1'b1;
            samp();
            chk({nm, ".req_valid"}, {63'd0, req_valid_o}, 64'd1);
            chk({nm, ".req_addr"}, {8'd0, req_addr_o}, {8'd0, exp_addr[l]});
            a = req_addr_o;
            tick(); req_ready_i = 1'b0;
            for (int d = 0; d < delay; d++) begin
                samp(); chk({nm, ".wait_quiet"}, {61'd0, req_valid_o, update_valid_o, fault_valid_o}, 64'd0);
                tick();
            end
            resp_valid_i = 1'b1; resp_data_i = mem_rd(a);
            samp(); chk({nm, ".resp_quiet"}, {61'd0, req_valid_o, update_valid_o, fault_valid_o}, 64'd0);
            tick(); resp_valid_i = 1'b0;
        end
        samp();
        if (exp_upd) begin
            va64 = {25'd0, va};
            chk({nm, ".upd_pulse"}, {62'd0, update_valid_o, fault_valid_o}, 64'd2);
            chk({nm, ".upd_vpn"}, {37'd0, update_vpn_o}, va64 >> 12);
            chk({nm, ".upd_asid"}, {60'd0, update_asid_o}, {60'd0, asid});
            chk({nm, ".upd_size"}, {62'd0, update_is_1G_o, update_is_2M_o}, {62'd0, exp_1g, exp_2m});
            chk({nm, ".upd_content"}, update_content_o, exp_content);
        end else begin
            chk({nm, ".flt_pulse"}, {62'd0, update_valid_o, fault_valid_o}, 64'd1);
            chk({nm, ".flt_vaddr"}, {25'd0, fault_vaddr_o}, {25'd0, va});
        end
        tick();
        samp(); chk({nm, ".after"}, {60'd0, update_valid_o, fault_valid_o, busy_o, miss_ready_o}, 64'd1);
        tick();
    endtask

    // Flush scenarios on the 4K table: 0 WAIT+late resp, 1 REQ stalled, 2 REQ accepted, 3 WAIT+resp.
    task automatic flush_case(input int mode, input string nm);
        miss_vaddr_i = V4K; miss_valid_i = 1'b1;
        tick(); miss_valid_i = 1'b0;
        if (mode == 1 || mode == 2) begin
            flush_i = 1'b1; req_ready_i = (mode == 2);
            samp(); chk({nm, ".req_valid"}, {63'd0, req_valid_o}, 64'd1);
            tick(); flush_i = 1'b0; req_ready_i = 1'b0;
            samp(); chk({nm, ".state"}, {62'd0, busy_o, req_valid_o}, (mode == 2) ? 64'd2 : 64'd0);
            tick();
            if (mode == 2) begin
                resp_valid_i = 1'b1; resp_data_i = mem_rd(56'h100008);
                samp(); chk({nm, ".drain_busy"}, {63'd0, busy_o}, 64'd1);
                tick(); resp_valid_i = 1'b0;
            end
        end else begin
            req_ready_i = 1'b1;
            samp(); chk({nm, ".req_valid"}, {63'd0, req_valid_o}, 64'd1);
            tick(); req_ready_i = 1'b0;
            flush_i = 1'b1; miss_valid_i = 1'b1;
            resp_valid_i = (mode == 3); resp_data_i = mem_rd(56'h100008);
            samp(); chk({nm, ".miss_blocked"}, {63'd0, miss_ready_o}, 64'd0);
            tick(); flush_i = 1'b0; miss_valid_i = 1'b0; resp_valid_i = 1'b0;
            if (mode == 0) begin
                for (int i = 0; i < 4; i++) begin
                    samp(); chk({nm, ".drain"}, {60'd0, busy_o, req_valid_o, update_valid_o, fault_valid_o}, 64'd8);
                    tick();
                end
                resp_valid_i = 1'b1;
                samp(); chk({nm, ".drain_resp"}, {60'd0, busy_o, req_valid_o, update_valid_o, fault_valid_o}, 64'd8);
                tick(); resp_valid_i = 1'b0;
            end
        end
        samp(); chk({nm, ".idle"}, {60'd0, busy_o, update_valid_o, fault_valid_o, miss_ready_o}, 64'd1);
        tick();
        samp(); chk({nm, ".quiet"}, {62'd0, update_valid_o, fault_valid_o}, 64'd0);
        tick();
    endtask

    task automatic build_4k();
        mem.delete();
        satp_ppn_i = 44'h100;
        mem[56'h100008] = mk_pte(44'h200, 8'h01);
        mem[56'h200008] = mk_pte(44'h300, 8'h01);
        mem[56'h300018] = mk_pte(44'h80000, 8'hCF);
    endtask

    // Random page table along the path of a random vaddr.
    task automatic gen_random(output logic [38:0] va);
        logic [63:0]     r;
        logic [7:0]      fl;
        longint unsigned ppn, vl, a, lp;
        int              kind;
        bit              stop;
        mem.delete();
        r = {$urandom, $urandom}; satp_ppn_i = r[43:0];
        r = {$urandom, $urandom}; va = r[38:0];
        vl = va; ppn = satp_ppn_i; stop = 1'b0;
        for (int lvl = 2; lvl >= 0 && !stop; lvl--) begin
            a    = ppn * 4096 + ((vl >> (12 + 9 * lvl)) % 512) * 8;
            kind = int'($urandom_range(0, 9));
            r    = {$urandom, $urandom};
            lp   = r[43:0];
            fl   = r[51:44];
            if (kind == 0) begin
                fl[0] = 1'b0; stop = 1'b1;
            end else if (kind == 1) begin
                fl[0] = 1'b1; fl[1] = 1'b0; fl[2] = 1'b1; stop = 1'b1;
            end else if (kind <= 5) begin
                fl[0] = 1'b1;
                if (!fl[1]) fl[3] = 1'b1;
                fl[2] = fl[2] & fl[1];
                if (lvl > 0) begin
                    lp = lp & ~((64'd1 << (9 * lvl)) - 1);
                    if (kind == 5) lp = lp | (64'd1 << $urandom_range(0, 9 * lvl - 1));
                end
                stop = 1'b1;
            end else begin
                fl[0] = 1'b1; fl[3:1] = 3'b000;
            end
            mem[a[55:0]] = {r[63:54], lp[43:0], 2'b00, fl};
            ppn = lp;
        end
    endtask

    initial begin
        logic [38:0] va;
        logic [31:0] r;
        rst_i = 1'b1; flush_i = 1'b0; en_translation_i = 1'b1; satp_ppn_i = 44'd0;
        asid_i = '0; miss_valid_i = 1'b0; miss_vaddr_i = 39'd0; req_ready_i = 1'b0;
        resp_valid_i = 1'b0; resp_data_i = 64'd0;
        tick(); tick();
        samp(); chk("reset.ctrl", {59'd0, miss_ready_o, busy_o, req_valid_o, update_valid_o, fault_valid_o}, 64'd0);
        tick(); rst_i = 1'b0;
        samp();
        chk("reset.req_addr", {8'd0, req_addr_o}, 64'd0);
        chk("reset.content", update_content_o, 64'd0);
        chk("reset.data", {25'd0, fault_vaddr_o} | {37'd0, update_vpn_o}, 64'd0);
        chk("reset.idle", {62'd0, busy_o, miss_ready_o}, 64'd1);
        tick();

        // Translation disabled: the miss is ignored.
        en_translation_i = 1'b0; miss_valid_i = 1'b1; miss_vaddr_i = V4K;
        samp(); chk("en_off.ready", {63'd0, miss_ready_o}, 64'd0);
        tick(); miss_valid_i = 1'b0; en_translation_i = 1'b1;
        samp(); chk("en_off.busy", {63'd0, busy_o}, 64'd0);
        tick();

        build_4k();
        walk(V4K, 4'h3, 0, 0, "walk4k");

        mem.delete();
        mem[56'h100008] = mk_pte(44'h40000, 8'hCF);
        walk(V4K, 4'h9, 0, 0, "leaf1g");
        mem[56'h100008] = mk_pte(44'h40001, 8'hCF);
        walk(V4K, 4'h9, 0, 0, "mis1g");

        build_4k();
        mem[56'h200008] = mk_pte(44'h1200, 8'hC3);
        walk(V4K, 4'h2, 0, 1, "leaf2m");

        build_4k();
        mem[56'h300018] = 64'd0;
        walk(V4K, 4'h1, 0, 0, "l0_invalid");

        build_4k();
        mem[56'h100008] = mk_pte(44'h200, 8'h21);
        walk(V4K, 4'h5, 4, 1, "stall_g");

        build_4k();
        mem[56'h300018] = mk_pte(44'h80000, 8'h8F);
        walk(V4K, 4'h6, 0, 0, "a0_leaf");

        build_4k();
        flush_case(0, "flush_wait");
        flush_case(1, "flush_req");
        flush_case(2, "flush_req_acc");
        flush_case(3, "flush_wait_resp");
        walk(V4K, 4'h7, 0, 0, "post_flush");

        // Flush in IDLE beats a simultaneous miss.
        flush_i = 1'b1; miss_valid_i = 1'b1;
        samp(); chk("idle_flush.ready", {63'd0, miss_ready_o}, 64'd0);
        tick(); flush_i = 1'b0; miss_valid_i = 1'b0;
        samp(); chk("idle_flush.busy", {63'd0, busy_o}, 64'd0);
        tick();

        for (int i = 0; i < 40; i++) begin
            gen_random(va);
            r = $urandom;
            walk(va, r[AW-1:0], int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
